// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: opcode patterns, ALU op classes, control bundle.
package legv8_pkg;

  localparam logic [4:0] XZR_IDX = 5'd31;

  // Opcode value/mask pairs; mask bits at 0 are don't-care.
  localparam logic [10:0] OP_ADDS   = 11'b10101011000;
  localparam logic [10:0] OP_SUBS   = 11'b11101011000;
  localparam logic [10:0] OP_ADDI   = 11'b10010001000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] OP_BCOND  = 11'b01010100000;
  localparam logic [10:0] OP_B      = 11'b00010100000;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_ADDI = 11'b11111111110;
  localparam logic [10:0] MASK_CB   = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_PASSB = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    uncond_branch;
  } ctrl_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == (val & mask);
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational LEGv8 main decoder: opcode -> control bundle and register fields.
module main_decoder
  import legv8_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [4:0]  rd,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic        uses_rm,
  output logic        illegal
);

  logic [10:0] op;
  logic        unused_imm;

  assign op         = instr[31:21];
  assign rd         = instr[4:0];
  assign rn         = instr[9:5];
  assign unused_imm = ^instr[15:10];

  // Decode the opcode into controls, second-source selection and legality.
  always_comb begin
    ctrl    = '0;
    rm      = instr[20:16];
    uses_rm = 1'b0;
    illegal = 1'b0;
    if (op_match(op, OP_ADDS, MASK_FULL) || op_match(op, OP_SUBS, MASK_FULL)) begin
      ctrl.alu_op    = ALU_RTYPE;
      ctrl.reg_write = 1'b1;
      uses_rm        = 1'b1;
    end else if (op_match(op, OP_ADDI, MASK_ADDI)) begin
      ctrl.alu_op    = ALU_RTYPE;
      ctrl.reg_write = 1'b1;
      ctrl.alu_src   = 1'b1;
    end else if (op_match(op, OP_LDUR, MASK_FULL)) begin
      ctrl.alu_op     = ALU_ADD;
      ctrl.alu_src    = 1'b1;
      ctrl.mem_read   = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.reg_write  = 1'b1;
    end else if (op_match(op, OP_STUR, MASK_FULL)) begin
      ctrl.alu_op    = ALU_ADD;
      ctrl.alu_src   = 1'b1;
      ctrl.mem_write = 1'b1;
      rm             = instr[4:0];
      uses_rm        = 1'b1;
    end else if (op_match(op, OP_CBZ, MASK_CB)) begin
      ctrl.alu_op = ALU_PASSB;
      ctrl.branch = 1'b1;
      rm          = instr[4:0];
      uses_rm     = 1'b1;
    end else if (op_match(op, OP_BCOND, MASK_CB)) begin
      ctrl.alu_op = ALU_PASSB;
      ctrl.branch = 1'b1;
    end else if (op_match(op, OP_B, MASK_B)) begin
      ctrl.alu_op        = ALU_ADD;
      ctrl.uncond_branch = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID stage control: decode, load-use hazard detection and the ID/EX control register.
module id_ex_control_stage
  import legv8_pkg::*;
#(
  parameter int unsigned HAZARD_EN = 1,
  parameter logic [4:0]  XZR_IDX   = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic        flush,
  input  logic        ex_stall,
  output logic        hazard_stall,
  output logic        ex_valid,
  output logic [1:0]  ex_alu_op,
  output logic [10:0] ex_opcode,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic        ex_branch,
  output logic        ex_uncond_branch,
  output logic        ex_illegal,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rn,
  output logic [4:0]  ex_rm
);

  ctrl_t      dec_ctrl;
  ctrl_t      ex_ctrl;
  logic [4:0] dec_rd;
  logic [4:0] dec_rn;
  logic [4:0] dec_rm;
  logic       dec_uses_rm;
  logic       dec_illegal;

  main_decoder u_dec (
    .instr   (instr_in),
    .ctrl    (dec_ctrl),
    .rd      (dec_rd),
    .rn      (dec_rn),
    .rm      (dec_rm),
    .uses_rm (dec_uses_rm),
    .illegal (dec_illegal)
  );

  assign ex_alu_op        = ex_ctrl.alu_op;
  assign ex_reg_write     = ex_ctrl.reg_write;
  assign ex_mem_read      = ex_ctrl.mem_read;
  assign ex_mem_write     = ex_ctrl.mem_write;
  assign ex_mem_to_reg    = ex_ctrl.mem_to_reg;
  assign ex_alu_src       = ex_ctrl.alu_src;
  assign ex_branch        = ex_ctrl.branch;
  assign ex_uncond_branch = ex_ctrl.uncond_branch;

  // Load-use check against the load sitting in ID/EX; suppressed while EX is
  // stalled or flushed since those already override the register update.
  always_comb begin
    hazard_stall = 1'b0;
    if (HAZARD_EN != 0 && !reset && instr_valid && ex_valid && ex_ctrl.mem_read &&
        !ex_stall && !flush && ex_rd != XZR_IDX &&
        (ex_rd == dec_rn || (dec_uses_rm && ex_rd == dec_rm)))
      hazard_stall = 1'b1;
  end

  // ID/EX register: flush > stall-hold > bubble > normal load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
      ex_opcode  <= '0;
      ex_rd      <= '0;
      ex_rn      <= '0;
      ex_rm      <= '0;
    end else if (flush || (!ex_stall && hazard_stall)) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid   <= instr_valid;
      ex_ctrl    <= instr_valid ? dec_ctrl : '0;
      ex_illegal <= instr_valid & dec_illegal;
      ex_opcode  <= instr_in[31:21];
      ex_rd      <= dec_rd;
      ex_rn      <= dec_rn;
      ex_rm      <= dec_rm;
    end
  end

endmodule
